pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter SEG, default 4, number of carry segments/pipeline stages; WIDTH SHALL be an integer multiple of SEG; SW = WIDTH/SEG.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result bits.
REQ-013 SHALL have port cout  output  1  unsigned carry-out of MSB.
REQ-014 SHALL have port ovf  output  1  signed two's-complement overflow.

Function
REQ-015 Stage k (0..SEG-1) SHALL add bits [k*SW +: SW] of the operands plus the registered carry from stage k-1 (stage 0 uses cin); higher-segment operand bits SHALL be delayed in skew registers so each segment sees its operands in step with its carry.
REQ-016 Each stage SHALL register its SW sum bits, its carry-out, and a valid bit; no combinational carry path SHALL span more than SW bits.
REQ-017 Latency SHALL be exactly SEG cycles from an accepted input (in_valid & in_ready) to out_valid with no stall; throughput one result per cycle.
REQ-018 Global advance enable SHALL be en = !out_valid | out_ready; in_ready SHALL equal en; when en=0 every pipeline register, including valid bits, SHALL hold.
REQ-019 A cycle with en=1 and in_valid=0 SHALL insert a bubble (stage-0 valid=0); bubbles SHALL propagate and are not collapsed.
REQ-020 sum, cout, ovf SHALL be driven from the final stage registers; held stable while out_valid=1 and out_ready=0.
REQ-021 sum SHALL equal (a + b + cin) mod 2^WIDTH; cout SHALL be bit WIDTH of the full sum.
REQ-022 ovf SHALL be 1 iff a[WIDTH-1]==b_eff[WIDTH-1] and sum[WIDTH-1] differs, where b_eff is the operand actually added at the MSB.
REQ-023 Simultaneous output handshake and input acceptance in one cycle SHALL both complete (full throughput under out_ready=1).
REQ-024 Data registers MAY be left unchanged when the corresponding valid is 0; outputs are only meaningful when out_valid=1.

Reset
REQ-025 On rst_n=0 all valid bits SHALL clear asynchronously; out_valid=0, sum=0, cout=0, ovf=0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight results; no result SHALL emerge after deassertion without a new accepted input.
REQ-027 in_ready SHALL be 1 during and immediately after reset (out_valid=0).

Configuration
REQ-028 Macro PIPE_ADDER_SUB_EN defined: SHALL add port sub  input  1  sampled with operands; sub=1 computes a - b as a + ~b + 1, with cin ignored; cout=1 means no borrow; ovf uses b_eff = ~b; sub SHALL travel with its operands through the pipeline.
REQ-029 Macro PIPE_ADDER_SUB_EN undefined: port sub SHALL NOT exist; block is addition only per REQ-021.

Verification (WIDTH=16, SEG=4)
REQ-030 Reset then a=0x00FF, b=0x0001, cin=0, out_ready=1 -> out_valid exactly 4 cycles later, sum=0x0100, cout=0, ovf=0 (carry crosses segment).
REQ-031 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 stages).
REQ-032 a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0; a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1.
REQ-033 Stream 8 back-to-back inputs, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, no result lost/duplicated, results in order and all correct.
REQ-034 Accept 3 inputs, assert rst_n=0 for 1 cycle -> out_valid=0 immediately and stays 0 until a new input completes 4 cycles after acceptance.
REQ-035 With PIPE_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.

Source files
------------

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// PIPE_ADDER_SUB_EN adds the per-operand subtract select.
interface pipe_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef PIPE_ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
`ifdef PIPE_ADDER_SUB_EN
      output sub,
`endif
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
`ifdef PIPE_ADDER_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipe_adder.sv
// Carry-segmented pipelined adder: SEG stages of SW bits, one result per cycle.
// Define PIPE_ADDER_SUB_EN to add a subtract mode selected by bus.sub.
module pipe_adder #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_adder_if.slave bus
);
   localparam int SW = WIDTH / SEG;

   // Stage k registers: operands still to be consumed, partial sum, carry, valid.
   logic [WIDTH-1:0] a_p   [SEG];
   logic [WIDTH-1:0] b_p   [SEG];
   logic [WIDTH-1:0] s_p   [SEG];
   logic             c_p   [SEG];
   logic             vld_p [SEG];
   logic             ovf_p;
`ifdef PIPE_ADDER_SUB_EN
   logic             sub_p [SEG];
   logic             sub_in [SEG];
`endif

   logic [WIDTH-1:0] a_in   [SEG];
   logic [WIDTH-1:0] b_in   [SEG];
   logic [WIDTH-1:0] s_nxt  [SEG];
   logic             ci_in  [SEG];
   logic             vld_in [SEG];
   logic [SW:0]      add_c  [SEG];
   logic             inv_msb;
   logic             ovf_nxt;
   logic             en;

   function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
      return (sa == sb) && (ss != sa);
   endfunction

   assign en             = !vld_p[SEG-1] | bus.out_ready;
   assign bus.in_ready   = en;
   assign bus.out_valid  = vld_p[SEG-1];
   assign bus.sum        = s_p[SEG-1];
   assign bus.cout       = c_p[SEG-1];
   assign bus.ovf        = ovf_p;

   always_comb begin
      logic [WIDTH-1:0] s_base;
      logic [SW-1:0]    b_seg;
      logic             inv;
      inv_msb = 1'b0;
      for (int k = 0; k < SEG; k++) begin
         if (k == 0) begin
            a_in[k]   = bus.a;
            b_in[k]   = bus.b;
            vld_in[k] = bus.in_valid;
            s_base    = '0;
`ifdef PIPE_ADDER_SUB_EN
            sub_in[k] = bus.sub;
            // Subtraction forces the +1 of two's-complement negation; cin is ignored.
            ci_in[k]  = bus.sub | bus.cin;
`else
            ci_in[k]  = bus.cin;
`endif
         end else begin
            a_in[k]   = a_p[k-1];
            b_in[k]   = b_p[k-1];
            vld_in[k] = vld_p[k-1];
            s_base    = s_p[k-1];
            ci_in[k]  = c_p[k-1];
`ifdef PIPE_ADDER_SUB_EN
            sub_in[k] = sub_p[k-1];
`endif
         end
`ifdef PIPE_ADDER_SUB_EN
         inv = sub_in[k];
`else
         inv = 1'b0;
`endif
         b_seg    = b_in[k][k*SW +: SW] ^ {SW{inv}};
         add_c[k] = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_seg} + {{SW{1'b0}}, ci_in[k]};
         s_nxt[k] = s_base;
         s_nxt[k][k*SW +: SW] = add_c[k][SW-1:0];
         if (k == SEG-1) inv_msb = inv;
      end
      ovf_nxt = add_ovf(a_in[SEG-1][WIDTH-1], b_in[SEG-1][WIDTH-1] ^ inv_msb,
                        add_c[SEG-1][SW-1]);
   end

   // Only valids and the output stage are reset; data elsewhere loads only with a valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SEG; k++) vld_p[k] <= 1'b0;
         s_p[SEG-1] <= '0;
         c_p[SEG-1] <= 1'b0;
         ovf_p      <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < SEG; k++) begin
            vld_p[k] <= vld_in[k];
            if (vld_in[k]) begin
               a_p[k] <= a_in[k];
               b_p[k] <= b_in[k];
               s_p[k] <= s_nxt[k];
               c_p[k] <= add_c[k][SW];
`ifdef PIPE_ADDER_SUB_EN
               sub_p[k] <= sub_in[k];
`endif
            end
         end
         if (vld_in[SEG-1]) ovf_p <= ovf_nxt;
      end
   end
endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=16, SEG=4).
`timescale 1ns/1ps
module tb_pipe_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   pipe_adder_if #(.WIDTH(16)) bus ();
   pipe_adder #(.WIDTH(16), .SEG(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           output int lat, output logic [15:0] s, output logic co, output logic ov);
      bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      s = bus.sum; co = bus.cout; ov = bus.ovf;
      tick();
   endtask

   task automatic test_reset();
      #3;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.sum !== 16'h0000) begin failures++; $display("FAIL rst_sum: got %h expected 0000", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL rst_cout: got %b expected 0", bus.cout); end
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
      tick(); tick();
      rst_n = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_vectors(input string name, input logic [15:0] va [4], input logic [15:0] vb [4],
                               input logic vc [4], input logic [17:0] vexp [4], input int n);
      int lat; logic [15:0] s; logic co, ov;
      for (int i = 0; i < n; i++) begin
         send_one(va[i], vb[i], vc[i], lat, s, co, ov);
         checks++; if (lat !== 4) begin failures++; $display("FAIL %s_lat[%0d]: got %0d expected 4", name, i, lat); end
         checks++; if (s !== vexp[i][15:0]) begin failures++; $display("FAIL %s_sum[%0d]: got %h expected %h", name, i, s, vexp[i][15:0]); end
         checks++; if (co !== vexp[i][17]) begin failures++; $display("FAIL %s_cout[%0d]: got %b expected %b", name, i, co, vexp[i][17]); end
         checks++; if (ov !== vexp[i][16]) begin failures++; $display("FAIL %s_ovf[%0d]: got %b expected %b", name, i, ov, vexp[i][16]); end
      end
   endtask

   // Expected values packed as {cout, ovf, sum}.
   task automatic test_carry();
      logic [15:0] va [4] = '{16'h00FF, 16'hFFFF, 16'h0000, 16'h0000};
      logic [15:0] vb [4] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
      logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [17:0] ve [4] = '{{2'b00, 16'h0100}, {2'b10, 16'h0000}, 18'h0, 18'h0};
      test_vectors("carry", va, vb, vc, ve, 2);
   endtask

   task automatic test_overflow();
      logic [15:0] va [4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
      logic [15:0] vb [4] = '{16'h0001, 16'h8000, 16'h0000, 16'h0000};
      logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
      logic [17:0] ve [4] = '{{2'b01, 16'h8000}, {2'b11, 16'h0000}, 18'h0, 18'h0};
      test_vectors("ovf", va, vb, vc, ve, 2);
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [8] = '{16'h0001, 16'h1234, 16'h00FF, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h7000, 16'hABCD};
      logic [15:0] vb [8] = '{16'h0002, 16'h4321, 16'h0F01, 16'h0001, 16'h7FFF, 16'hF0F0, 16'h1000, 16'h1111};
      logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [17:0] ve [8] = '{{2'b00, 16'h0003}, {2'b00, 16'h5555}, {2'b00, 16'h1000}, {2'b10, 16'h0000},
                              {2'b10, 16'h0000}, {2'b00, 16'hFFFF}, {2'b01, 16'h8000}, {2'b00, 16'hBCDE}};
      int idx_in = 0, idx_out = 0, cyc = 0, extra = 0;
      logic stall;
      while (idx_out < 8 && cyc < 60) begin
         stall = (cyc >= 6 && cyc <= 8);
         bus.out_ready = !stall;
         if (idx_in < 8) begin
            bus.a = va[idx_in]; bus.b = vb[idx_in]; bus.cin = vc[idx_in]; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (stall) begin
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready[cyc %0d]: got %b expected 0", cyc, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.sum !== ve[idx_out][15:0]) begin
               failures++; $display("FAIL b2b_hold[cyc %0d]: got valid %b sum %h expected valid 1 sum %h", cyc, bus.out_valid, bus.sum, ve[idx_out][15:0]); end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++; if ({bus.cout, bus.ovf, bus.sum} !== ve[idx_out]) begin
               failures++; $display("FAIL b2b_result[%0d]: got %h expected %h", idx_out, {bus.cout, bus.ovf, bus.sum}, ve[idx_out]); end
            idx_out++;
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) idx_in++;
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      checks++; if (idx_out !== 8) begin failures++; $display("FAIL b2b_count: got %0d results expected 8", idx_out); end
      for (int i = 0; i < 6; i++) begin
         if (bus.out_valid === 1'b1) extra++;
         tick();
      end
      checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_extra: got %0d extra results expected 0", extra); end
   endtask

   task automatic test_reset_mid();
      int lat, seen = 0; logic [15:0] s; logic co, ov;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.a = 16'h0100 * 16'(i + 1); bus.b = 16'h0001; bus.cin = 1'b0; bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid: got %b expected 1", bus.out_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.sum !== 16'h0000) begin failures++; $display("FAIL mid_async_sum: got %h expected 0000", bus.sum); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid !== 1'b0) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL mid_ghost: got %0d valid cycles expected 0", seen); end
      send_one(16'h1111, 16'h2222, 1'b0, lat, s, co, ov);
      checks++; if (lat !== 4) begin failures++; $display("FAIL mid_new_lat: got %0d expected 4", lat); end
      checks++; if (s !== 16'h3333) begin failures++; $display("FAIL mid_new_sum: got %h expected 3333", s); end
   endtask

`ifdef PIPE_ADDER_SUB_EN
   task automatic test_sub();
      int lat; logic [15:0] s; logic co, ov;
      bus.sub = 1'b1;
      send_one(16'h0005, 16'h0007, 1'b0, lat, s, co, ov);
      checks++; if (s !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0) begin failures++;
         $display("FAIL sub_neg: got sum %h cout %b ovf %b expected FFFE 0 0", s, co, ov); end
      send_one(16'h8000, 16'h0001, 1'b1, lat, s, co, ov);
      checks++; if (s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1) begin failures++;
         $display("FAIL sub_ovf: got sum %h cout %b ovf %b expected 7FFF 1 1", s, co, ov); end
      bus.sub = 1'b0;
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
      bus.sub = 1'b0;
`endif
      test_reset();
      test_carry();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
`ifdef PIPE_ADDER_SUB_EN
      test_sub();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
